counter_timer_low: RTL and testbench
====================================

# counter_timer_low

Low 32-bit word of the Caravel counter/timer pair. Runs standalone as a 32-bit up/down counter-timer, or chained as the low half of a 64-bit counter. In chained mode it feeds the high-word counter with a carry/borrow strobe, an offset hint and its run enable, and consumes the high word's stop flag to detect the full 64-bit terminal count. Sits behind the same Wishbone register shim as the high word; register decode is outside this block.

## Interface
No parameters.
- resetn  input  1  asynchronous, active-low reset
- clkin  input  1  clock; all state on rising edge
- reg_cfg_we  input  1  config write strobe
- reg_cfg_di  input  32  config write data; [0] enable, [1] oneshot, [2] updown (1=up), [3] chain, [4] irq_ena
- reg_cfg_do  output  32  {27'd0, irq_ena, chain, updown, oneshot, enable}
- reg_val_we  input  4  per-byte write enables, terminal/reload value (value_reset)
- reg_val_di  input  32  value_reset write data
- reg_val_do  output  32  value_reset
- reg_dat_we  input  4  per-byte write enables, current count (value_cur)
- reg_dat_di  input  32  value_cur write data
- reg_dat_do  output  32  value_cur
- enable_in  input  1  enable from high word (used only when chain=1)
- stop_in  input  1  high word at its terminal condition (used only when chain=1)
- strobe  output  1  combinational carry/borrow to high word
- is_offset  output  1  combinational; high word must compare value+1
- stop_out  output  1  registered stop flag
- enable_out  output  1  equals config enable bit
- irq_out  output  1  registered interrupt

## Operation
- Reset: all config bits, value_reset, value_cur, stop_out, irq_out, lastenable = 0. Outputs are therefore 0.
- loc_enable = chain ? (enable & enable_in) : enable. lastenable <= loc_enable every cycle.
- Priority per cycle: any reg_dat_we bit set > loc_enable counting > idle.
  - reg_dat_we set: write the selected bytes only. No count, strobe=0. stop_out and irq_out hold.
- Idle (loc_enable=0): value_cur holds; stop_out <= 0; irq_out holds.
- Start (loc_enable=1, lastenable=0): value_cur <= 0 (up) or value_reset (down); stop_out <= 0; strobe=0.
- Counting, up (updown=1). Match = value_cur==value_reset, additionally qualified by stop_in when chain=1.
  - On match, oneshot: value_cur holds; stop_out <= 1.
  - On match, continuous: value_cur <= 0; stop_out <= 1 for one cycle.
  - Otherwise: value_cur <= value_cur+1 (wraps mod 2^32); stop_out <= 0.
  - strobe = chain & counting & !match & value_cur==32'hFFFF_FFFF.
- Counting, down (updown=0). Match = value_cur==0, additionally qualified by stop_in when chain=1.
  - On match, oneshot: value_cur holds; stop_out <= 1.
  - On match, continuous: value_cur <= value_reset; stop_out <= 1 for one cycle.
  - Otherwise: value_cur <= value_cur-1 (wraps); stop_out <= 0.
  - strobe = chain & counting & !match & value_cur==0.
- is_offset = chain & updown & loc_enable & value_cur==32'hFFFF_FFFF.
- irq_out <= irq_ena & stop_out, updated only in counting/start cycles.
- Config or value_reset writes take effect the next cycle. Changing value_reset mid-count is legal; the match uses the new value.

## Timing
- Register reads (reg_*_do) are combinational from state, zero latency.
- First count edge is one cycle after loc_enable rises; the start cycle only loads.
- strobe is asserted in the same cycle as the wrapping edge; the high word samples it on that edge.
- stop_out rises on the edge that detects the match. irq_out follows one cycle later.
- Asynchronous resetn mid-count clears everything immediately. Counting resumes only through a fresh start cycle.

## Test plan
- Standalone up, oneshot, value_reset=5, enable: value_cur goes 0,1,2,3,4,5 then holds; stop_out=1 from the cycle after reaching 5; with irq_ena, irq_out=1 one cycle after that.
- Standalone down, continuous, value_reset=3: value_cur sequence 3,2,1,0,3,2…; stop_out pulses one cycle per reload; strobe stays 0.
- Chained up, value_cur written to 32'hFFFF_FFFE: is_offset=1 when value is FFFF_FFFF; strobe=1 for exactly that cycle; next value is 0.
- Chained down, value_cur=0, stop_in=0: strobe=1 and value becomes FFFF_FFFF. Repeat with stop_in=1 and oneshot: stop_out=1, value holds at 0, strobe=0.
- reg_dat_we=4'b0010 with data 32'h0000_AB00 during counting: only byte 1 changes; no increment that cycle.
- Drop enable_in while chain=1: count freezes and stop_out=0. Re-raise it: start cycle reloads the start value. Then assert resetn=0 mid-count: all outputs 0 asynchronously.

Source files
------------

// File: rtl/counter_timer_low.sv
// counter_timer_low: low 32-bit word of the counter/timer pair.
// Counts standalone as a 32-bit up/down timer, or as the low half of a
// 64-bit chained counter that hands carry/borrow strobes to the high word.
module counter_timer_low (
   input  logic        resetn,
   input  logic        clkin,
   input  logic        reg_cfg_we,
   input  logic [31:0] reg_cfg_di,
   output logic [31:0] reg_cfg_do,
   input  logic [3:0]  reg_val_we,
   input  logic [31:0] reg_val_di,
   output logic [31:0] reg_val_do,
   input  logic [3:0]  reg_dat_we,
   input  logic [31:0] reg_dat_di,
   output logic [31:0] reg_dat_do,
   input  logic        enable_in,
   input  logic        stop_in,
   output logic        strobe,
   output logic        is_offset,
   output logic        stop_out,
   output logic        enable_out,
   output logic        irq_out
);

   localparam int unsigned DW     = 32;
   localparam int unsigned NB     = DW / 8;
   localparam int unsigned CFG_W  = 5;
   localparam logic [DW-1:0] ALL_ONES = '1;

   // Config bits in register order, enable at bit 0.
   typedef struct packed {
      logic irq_ena;
      logic chain;
      logic updown;
      logic oneshot;
      logic enable;
   } cfg_t;

   cfg_t          cfg_q;
   logic [DW-1:0] value_reset_q;
   logic [DW-1:0] value_cur_q;
   logic [DW-1:0] value_cur_d;
   logic          stop_q;
   logic          stop_d;
   logic          irq_q;
   logic          irq_d;
   logic          lastenable_q;

   logic          loc_enable_c;
   logic          dat_wr_c;
   logic          start_c;
   logic          count_c;
   logic          term_c;
   logic          match_c;
   logic          wrap_c;
   logic          unused_cfg_bits;

   // Byte-lane merge for the per-byte writable registers.
   function automatic logic [DW-1:0] byte_merge(
      input logic [DW-1:0] cur,
      input logic [DW-1:0] din,
      input logic [NB-1:0] we
   );
      logic [DW-1:0] res;
      res = cur;
      for (int unsigned i = 0; i < NB; i++) begin
         if (we[i]) res[i*8 +: 8] = din[i*8 +: 8];
      end
      return res;
   endfunction

   assign unused_cfg_bits = &{1'b0, reg_cfg_di[31:CFG_W]};

   // Register read-back and status outputs straight from state.
   assign reg_cfg_do = {(DW - CFG_W)'(0), cfg_q};
   assign reg_val_do = value_reset_q;
   assign reg_dat_do = value_cur_q;
   assign stop_out   = stop_q;
   assign irq_out    = irq_q;
   assign enable_out = cfg_q.enable;

   // Cycle classification and terminal/wrap detection.
   always_comb begin
      loc_enable_c = cfg_q.chain ? (cfg_q.enable & enable_in) : cfg_q.enable;
      dat_wr_c     = |reg_dat_we;
      start_c      = !dat_wr_c & loc_enable_c & !lastenable_q;
      count_c      = !dat_wr_c & loc_enable_c & lastenable_q;
      term_c       = cfg_q.updown ? (value_cur_q == value_reset_q)
                                  : (value_cur_q == '0);
      match_c      = term_c & (!cfg_q.chain | stop_in);
      wrap_c       = cfg_q.updown ? (value_cur_q == ALL_ONES)
                                  : (value_cur_q == '0);
      strobe       = cfg_q.chain & count_c & !match_c & wrap_c;
      is_offset    = cfg_q.chain & cfg_q.updown & loc_enable_c &
                     (value_cur_q == ALL_ONES);
   end

   // Next count, stop and interrupt state; bus write beats counting.
   always_comb begin
      value_cur_d = value_cur_q;
      stop_d      = stop_q;
      irq_d       = irq_q;
      if (dat_wr_c) begin
         value_cur_d = byte_merge(value_cur_q, reg_dat_di, reg_dat_we);
      end else if (start_c) begin
         value_cur_d = cfg_q.updown ? '0 : value_reset_q;
         stop_d      = 1'b0;
         irq_d       = cfg_q.irq_ena & stop_q;
      end else if (count_c) begin
         irq_d = cfg_q.irq_ena & stop_q;
         if (match_c) begin
            stop_d = 1'b1;
            if (!cfg_q.oneshot) begin
               value_cur_d = cfg_q.updown ? '0 : value_reset_q;
            end
         end else begin
            stop_d      = 1'b0;
            value_cur_d = cfg_q.updown ? (value_cur_q + DW'(1))
                                       : (value_cur_q - DW'(1));
         end
      end else begin
         stop_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         cfg_q         <= '0;
         value_reset_q <= '0;
         value_cur_q   <= '0;
         stop_q        <= 1'b0;
         irq_q         <= 1'b0;
         lastenable_q  <= 1'b0;
      end else begin
         if (reg_cfg_we) cfg_q <= cfg_t'(reg_cfg_di[CFG_W-1:0]);
         value_reset_q <= byte_merge(value_reset_q, reg_val_di, reg_val_we);
         value_cur_q   <= value_cur_d;
         stop_q        <= stop_d;
         irq_q         <= irq_d;
         lastenable_q  <= loc_enable_c;
      end
   end

endmodule

// File: tb/tb_counter_timer_low.sv
// Scoreboard bench for counter_timer_low: each step queues the expected
// outputs, advances one clock, then pops and compares against the DUT.
module tb_counter_timer_low;

   logic        resetn;
   logic        clkin;
   logic        reg_cfg_we;
   logic [31:0] reg_cfg_di;
   logic [31:0] reg_cfg_do;
   logic [3:0]  reg_val_we;
   logic [31:0] reg_val_di;
   logic [31:0] reg_val_do;
   logic [3:0]  reg_dat_we;
   logic [31:0] reg_dat_di;
   logic [31:0] reg_dat_do;
   logic        enable_in;
   logic        stop_in;
   logic        strobe;
   logic        is_offset;
   logic        stop_out;
   logic        enable_out;
   logic        irq_out;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   localparam int S_CFG = 0, S_VAL = 1, S_DAT = 2, S_STB = 3,
                  S_OFS = 4, S_STOP = 5, S_EN = 6, S_IRQ = 7;

   counter_timer_low dut (
      .resetn     (resetn),
      .clkin      (clkin),
      .reg_cfg_we (reg_cfg_we),
      .reg_cfg_di (reg_cfg_di),
      .reg_cfg_do (reg_cfg_do),
      .reg_val_we (reg_val_we),
      .reg_val_di (reg_val_di),
      .reg_val_do (reg_val_do),
      .reg_dat_we (reg_dat_we),
      .reg_dat_di (reg_dat_di),
      .reg_dat_do (reg_dat_do),
      .enable_in  (enable_in),
      .stop_in    (stop_in),
      .strobe     (strobe),
      .is_offset  (is_offset),
      .stop_out   (stop_out),
      .enable_out (enable_out),
      .irq_out    (irq_out)
   );

   initial begin
      clkin = 1'b0;
      forever #5 clkin = ~clkin;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1);
   end

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_CFG:   return reg_cfg_do;
         S_VAL:   return reg_val_do;
         S_DAT:   return reg_dat_do;
         S_STB:   return {31'd0, strobe};
         S_OFS:   return {31'd0, is_offset};
         S_STOP:  return {31'd0, stop_out};
         S_EN:    return {31'd0, enable_out};
         default: return {31'd0, irq_out};
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [31:0] v);
      sb.push_back('{tag, sel, v});
   endtask

   task automatic tick();
      @(posedge clkin);
      @(negedge clkin);
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      #1;
   endtask

   task automatic write_cfg(input logic [31:0] v);
      reg_cfg_we = 1'b1;
      reg_cfg_di = v;
      tick();
      reg_cfg_we = 1'b0;
      #1;
   endtask

   task automatic write_val(input logic [31:0] v);
      reg_val_we = 4'hF;
      reg_val_di = v;
      tick();
      reg_val_we = 4'h0;
      #1;
   endtask

   task automatic test_reset();
      exp_t        e;
      logic [31:0] got;
      resetn = 1'b0;
      #1;
      push("rst_cfg", S_CFG, 0);   push("rst_val", S_VAL, 0);
      push("rst_dat", S_DAT, 0);   push("rst_strobe", S_STB, 0);
      push("rst_offset", S_OFS, 0); push("rst_stop", S_STOP, 0);
      push("rst_enable", S_EN, 0); push("rst_irq", S_IRQ, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         got = observe(e.sel);
         n_cmp++;
         if (got !== e.val) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.tag, got, e.val);
         end
      end
      tick();
      resetn = 1'b1;
      #1;
   endtask

   // Up, oneshot, reload 5, irq enabled.
   task automatic test_up_oneshot();
      exp_t        e;
      logic [31:0] got;
      apply_reset();
      write_val(32'd5);
      write_cfg(32'd23);
      for (int k = 0; k < 9; k++) begin
         if (k == 0) begin
            push("up_cfg_do", S_CFG, 32'd23);
            push("up_enable_out", S_EN, 32'd1);
            push("up_val_do", S_VAL, 32'd5);
         end
         push("up_value", S_DAT, (k < 5) ? 32'(k) : 32'd5);
         push("up_stop", S_STOP, (k >= 6) ? 32'd1 : 32'd0);
         push("up_irq", S_IRQ, (k >= 7) ? 32'd1 : 32'd0);
         push("up_strobe", S_STB, 32'd0);
         tick();
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            got = observe(e.sel);
            n_cmp++;
            if (got !== e.val) begin
               n_bad++;
               $display("FAIL %s step %0d: got %h want %h", e.tag, k, got, e.val);
            end
         end
      end
   endtask

   // Down, continuous, reload 3.
   task automatic test_down_continuous();
      exp_t        e;
      logic [31:0] got;
      apply_reset();
      write_val(32'd3);
      write_cfg(32'd1);
      for (int k = 0; k < 9; k++) begin
         push("dn_value", S_DAT, 32'(3 - (k % 4)));
         push("dn_stop", S_STOP, (k > 0 && (k % 4) == 0) ? 32'd1 : 32'd0);
         push("dn_strobe", S_STB, 32'd0);
         push("dn_irq", S_IRQ, 32'd0);
         tick();
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            got = observe(e.sel);
            n_cmp++;
            if (got !== e.val) begin
               n_bad++;
               $display("FAIL %s step %0d: got %h want %h", e.tag, k, got, e.val);
            end
         end
      end
   endtask

   // Chained up across the 32-bit wrap.
   task automatic test_chain_up();
      exp_t        e;
      logic [31:0] got;
      logic [31:0] vals [3];
      logic [31:0] flag [3];
      vals[0] = 32'hFFFF_FFFE; vals[1] = 32'hFFFF_FFFF; vals[2] = 32'h0;
      flag[0] = 32'd0;         flag[1] = 32'd1;         flag[2] = 32'd0;
      apply_reset();
      enable_in = 1'b1;
      stop_in   = 1'b0;
      write_cfg(32'd13);
      for (int k = 0; k < 3; k++) begin
         if (k == 0) begin
            reg_dat_we = 4'hF;
            reg_dat_di = 32'hFFFF_FFFE;
         end
         push("cu_value", S_DAT, vals[k]);
         push("cu_offset", S_OFS, flag[k]);
         push("cu_strobe", S_STB, flag[k]);
         push("cu_enable_out", S_EN, 32'd1);
         tick();
         reg_dat_we = 4'h0;
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            got = observe(e.sel);
            n_cmp++;
            if (got !== e.val) begin
               n_bad++;
               $display("FAIL %s step %0d: got %h want %h", e.tag, k, got, e.val);
            end
         end
      end
   endtask

   // Chained down: borrow at 0, then oneshot stop qualified by stop_in.
   task automatic test_chain_down();
      exp_t        e;
      logic [31:0] got;
      apply_reset();
      enable_in = 1'b1;
      stop_in   = 1'b0;
      write_cfg(32'd9);
      for (int k = 0; k < 5; k++) begin
         if (k == 0) begin
            reg_dat_we = 4'hF;
            reg_dat_di = 32'h0;
         end
         if (k == 2) begin
            resetn = 1'b0;
            #1;
            resetn = 1'b1;
            stop_in = 1'b1;
            reg_cfg_we = 1'b1;
            reg_cfg_di = 32'd11;
            tick();
            reg_cfg_we = 1'b0;
         end
         case (k)
            0: begin push("cd_value", S_DAT, 32'h0); push("cd_strobe", S_STB, 32'd1); end
            1: begin push("cd_value", S_DAT, 32'hFFFF_FFFF); push("cd_strobe", S_STB, 32'd0); end
            2: begin push("cd1_value", S_DAT, 32'h0); push("cd1_strobe", S_STB, 32'd0);
                     push("cd1_stop", S_STOP, 32'd0); end
            default: begin push("cd1_value", S_DAT, 32'h0); push("cd1_strobe", S_STB, 32'd0);
                           push("cd1_stop", S_STOP, 32'd1); end
         endcase
         tick();
         reg_dat_we = 4'h0;
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            got = observe(e.sel);
            n_cmp++;
            if (got !== e.val) begin
               n_bad++;
               $display("FAIL %s step %0d: got %h want %h", e.tag, k, got, e.val);
            end
         end
      end
   endtask

   // Byte-lane write to the live count suppresses that cycle's increment.
   task automatic test_byte_write();
      exp_t        e;
      logic [31:0] got;
      logic [31:0] vals [5];
      vals[0] = 32'd0; vals[1] = 32'd1; vals[2] = 32'd2;
      vals[3] = 32'h0000_AB02; vals[4] = 32'h0000_AB03;
      apply_reset();
      write_val(32'd100);
      write_cfg(32'd5);
      for (int k = 0; k < 5; k++) begin
         if (k == 3) begin
            reg_dat_we = 4'b0010;
            reg_dat_di = 32'h0000_AB00;
         end
         push("bw_value", S_DAT, vals[k]);
         tick();
         reg_dat_we = 4'h0;
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            got = observe(e.sel);
            n_cmp++;
            if (got !== e.val) begin
               n_bad++;
               $display("FAIL %s step %0d: got %h want %h", e.tag, k, got, e.val);
            end
         end
      end
   endtask

   // Chained enable drop/restore, then asynchronous reset mid-count.
   task automatic test_enable_drop();
      exp_t        e;
      logic [31:0] got;
      logic [31:0] vals [8];
      logic [31:0] stp  [8];
      vals = '{32'd0, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd1};
      stp  = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
      apply_reset();
      enable_in = 1'b1;
      stop_in   = 1'b1;
      write_val(32'd2);
      write_cfg(32'd15);
      for (int k = 0; k < 9; k++) begin
         if (k == 4) enable_in = 1'b0;
         if (k == 6) enable_in = 1'b1;
         if (k < 8) begin
            push("ed_value", S_DAT, vals[k]);
            push("ed_stop", S_STOP, stp[k]);
            if (k == 4) push("ed_enable_out", S_EN, 32'd1);
            tick();
         end else begin
            push("ar_value", S_DAT, 32'd0); push("ar_cfg", S_CFG, 32'd0);
            push("ar_val", S_VAL, 32'd0);   push("ar_stop", S_STOP, 32'd0);
            push("ar_irq", S_IRQ, 32'd0);   push("ar_enable", S_EN, 32'd0);
            push("ar_strobe", S_STB, 32'd0); push("ar_offset", S_OFS, 32'd0);
            #2;
            resetn = 1'b0;
         end
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            got = observe(e.sel);
            n_cmp++;
            if (got !== e.val) begin
               n_bad++;
               $display("FAIL %s step %0d: got %h want %h", e.tag, k, got, e.val);
            end
         end
      end
      tick();
      resetn = 1'b1;
      #1;
   endtask

   initial begin
      resetn     = 1'b0;
      reg_cfg_we = 1'b0;
      reg_cfg_di = '0;
      reg_val_we = '0;
      reg_val_di = '0;
      reg_dat_we = '0;
      reg_dat_di = '0;
      enable_in  = 1'b0;
      stop_in    = 1'b0;
      test_reset();
      test_up_oneshot();
      test_down_continuous();
      test_chain_up();
      test_chain_down();
      test_byte_write();
      test_enable_drop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
